// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the WISC-SP20 pipeline sequencer: FSM states,
// stage indices, stall-cause priority encoding and the enable bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_DMEM,
        CAUSE_DEC,
        CAUSE_HALT,
        CAUSE_FLUSH,
        CAUSE_IMEM
    } cause_t;

    typedef struct packed {
        logic       pc;
        logic [3:0] en;
        logic [3:0] bub;
    } ctrl_t;

    // HALT wins over redirects and fetch stalls, loses to real hazards
    function automatic cause_t stall_cause(
        input logic dmem,
        input logic dec,
        input logic halt,
        input logic flush,
        input logic imem
    );
        if (dmem)       return CAUSE_DMEM;
        else if (dec)   return CAUSE_DEC;
        else if (halt)  return CAUSE_HALT;
        else if (flush) return CAUSE_FLUSH;
        else if (imem)  return CAUSE_IMEM;
        else            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating stall and redirect counters for the pipeline sequencer.
// Only instantiated when PIPE_PERF_EN is defined.
module pipe_ctrl_perf #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables/bubbles, valid tracking, fetch discard
// and HALT drain. Optional counters are built under PIPE_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_decode,
    input  logic             flush_fetch,
    input  logic             imem_stall,
    input  logic             imem_done,
    input  logic             dmem_stall,
    input  logic             halt_id,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_bubble,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_bubble,
    output logic [3:0]       stage_valid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t        state;
    logic          discard;
    logic [DW-1:0] cnt;
    logic [3:0]    valid;
    logic [3:0]    valid_nxt;
    cause_t        cause;
    ctrl_t         ctl;
    logic          drop;

    assign cause = stall_cause(dmem_stall, stall_decode, halt_id,
                               flush_fetch, imem_stall);

    always_comb begin
        ctl  = '0;
        drop = 1'b0;
        unique case (state)
            RUN: begin
                unique case (cause)
                    CAUSE_DMEM: begin
                        ctl.en[MEMWB]  = 1'b1;
                        ctl.bub[MEMWB] = 1'b1;
                    end
                    CAUSE_DEC: begin
                        ctl.en        = 4'b1110;
                        ctl.bub[IDEX] = 1'b1;
                    end
                    CAUSE_HALT, CAUSE_IMEM: begin
                        ctl.en        = '1;
                        ctl.bub[IFID] = 1'b1;
                    end
                    CAUSE_FLUSH: begin
                        ctl.pc        = 1'b1;
                        ctl.en        = '1;
                        ctl.bub[IFID] = 1'b1;
                    end
                    default: begin
                        // wrong-path word from an earlier redirect arrives
                        drop          = discard & imem_done;
                        ctl.pc        = ~drop;
                        ctl.en        = '1;
                        ctl.bub[IFID] = drop;
                    end
                endcase
            end
            DRAIN: begin
                if (dmem_stall) begin
                    ctl.en[MEMWB]  = 1'b1;
                    ctl.bub[MEMWB] = 1'b1;
                end else begin
                    ctl.en        = '1;
                    ctl.bub[IFID] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_nxt = valid;
        if (ctl.en[IFID])
            valid_nxt[IFID] = ~ctl.bub[IFID];
        for (int i = 1; i < 4; i++)
            if (ctl.en[i])
                valid_nxt[i] = ~ctl.bub[i] & valid[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            discard <= 1'b0;
            cnt     <= '0;
            valid   <= '0;
        end else begin
            valid <= valid_nxt;
            unique case (state)
                RUN: begin
                    if (cause == CAUSE_FLUSH && imem_stall)
                        discard <= 1'b1;
                    else if (imem_done)
                        discard <= 1'b0;
                    if (cause == CAUSE_HALT) begin
                        state <= DRAIN;
                        cnt   <= DW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (!dmem_stall) begin
                        if (cnt == DW'(1)) begin
                            state <= HALTED;
                            valid <= '0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_en         = ctl.pc;
    assign if_id_en      = ctl.en[IFID];
    assign if_id_bubble  = ctl.bub[IFID];
    assign id_ex_en      = ctl.en[IDEX];
    assign id_ex_bubble  = ctl.bub[IDEX];
    assign ex_mem_en     = ctl.en[EXMEM];
    assign mem_wb_en     = ctl.en[MEMWB];
    assign mem_wb_bubble = ctl.bub[MEMWB];
    assign stage_valid   = valid;
    assign halted        = (state == HALTED);

`ifdef PIPE_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (state == RUN) &&
                       (cause == CAUSE_DMEM || cause == CAUSE_DEC ||
                        cause == CAUSE_IMEM);
    assign flush_inc = (state == RUN) && (cause == CAUSE_FLUSH);

    pipe_ctrl_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_inc (stall_inc),
        .flush_inc (flush_inc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
